layer_color_mapper: RTL and testbench

Pipelined, parametrised successor to the single-screen color mapper. It resolves NUM_LAYERS prioritised sprite layers against a per-status background and looks each layer's color up in a run-time-writable palette. It fades the whole screen through black whenever the game status changes. It sits between the sprite/hit logic and the VGA DAC outputs, clocked at the pixel clock.

---
 rtl/layer_color_mapper_if.sv | 28 ++
 rtl/layer_color_mapper.sv | 115 +++++++++++
 tb/tb_layer_color_mapper.sv | 138 +++++++++++++
 3 files changed

// File: rtl/layer_color_mapper_if.sv
// layer_color_mapper_if: pixel, palette-write and VGA color bundle for the layer color mapper
interface layer_color_mapper_if #(
   parameter int NUM_LAYERS = 4,
   parameter int AW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
);
   logic                  frame_tick;
   logic [3:0]            status;
   logic [NUM_LAYERS-1:0] layer_hit;
   logic                  cover_black;
   logic [9:0]            DrawX;
   logic [9:0]            DrawY;
   logic                  pal_we;
   logic [AW-1:0]         pal_addr;
   logic [23:0]           pal_data;
   logic [7:0]            VGA_R;
   logic [7:0]            VGA_G;
   logic [7:0]            VGA_B;
   logic [3:0]            disp_status;
   logic                  fade_busy;
   modport master (
      output frame_tick, status, layer_hit, cover_black, DrawX, DrawY, pal_we, pal_addr, pal_data,
      input  VGA_R, VGA_G, VGA_B, disp_status, fade_busy
   );
   modport slave (
      input  frame_tick, status, layer_hit, cover_black, DrawX, DrawY, pal_we, pal_addr, pal_data,
      output VGA_R, VGA_G, VGA_B, disp_status, fade_busy
   );
endinterface

// File: rtl/layer_color_mapper.sv
// layer_color_mapper: prioritised sprite layers over a per-status background, palette lookup and frame-synchronous fade
module layer_color_mapper #(
   parameter int NUM_LAYERS = 4,
   parameter int FADE_LOG2 = 4
) (
   input logic Clk,
   input logic Reset,
   layer_color_mapper_if.slave bus
);
   localparam int LW = FADE_LOG2 + 1;
   localparam logic [LW-1:0] MAXL = LW'(1 << FADE_LOG2);
   typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} state_t;
   state_t state;
   logic [LW-1:0] level;
   logic [3:0] target;
   logic [3:0] disp;
   logic busy;
   logic [23:0] pal [NUM_LAYERS];
   logic [7:0] xs;
   logic [23:0] bg;
   logic [23:0] pix;
   logic layers_on;
   logic [23:0] c1;
   logic [LW-1:0] l1;
   function automatic logic [23:0] pal_init(input int i);
      return (i == 1) ? 24'hFFFF00 : (i == 2) ? 24'h404040 : (i == 3) ? 24'h101010 : 24'h000000;
   endfunction
   function automatic logic [7:0] scale(input logic [7:0] c, input logic [LW-1:0] l);
      logic [8+FADE_LOG2:0] p;
      p = {{LW{1'b0}}, c} * {8'd0, l};
      return p[FADE_LOG2 +: 8];
   endfunction
   assign xs = {1'b0, bus.DrawX[9:3]};
   assign layers_on = (disp == 4'b0100) || (disp == 4'b0010);
   assign bus.disp_status = disp;
   assign bus.fade_busy = busy;
   // Run-time palette; out-of-range addresses are dropped
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_LAYERS; i++) pal[i] <= pal_init(i);
      end else if (bus.pal_we && int'(bus.pal_addr) < NUM_LAYERS) begin
         pal[bus.pal_addr] <= bus.pal_data;
      end
   end
   // Fade FSM: level only moves on frame_tick so no frame mixes two brightness levels
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= FADE_IN;
         level <= '0;
         disp <= 4'b1000;
         target <= 4'b1000;
         busy <= 1'b1;
      end else begin
         if (bus.status != target) target <= bus.status;
         case (state)
            IDLE: begin
               if (target != disp) begin
                  state <= FADE_OUT;
                  busy <= 1'b1;
               end
            end
            FADE_OUT: begin
               if (bus.frame_tick) begin
                  if (level == '0) begin
                     disp <= target;
                     state <= FADE_IN;
                  end else begin
                     level <= level - 1'b1;
                  end
               end
            end
            FADE_IN: begin
               if (target != disp) begin
                  state <= FADE_OUT;
               end else if (bus.frame_tick) begin
                  level <= level + 1'b1;
                  if (level == MAXL - 1'b1) begin
                     state <= IDLE;
                     busy <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   end
   // Background by displayed status, then lowest-index hit layer wins
   always_comb begin
      bg = (disp == 4'b1000) ? (bus.cover_black ? 24'h000000 : 24'hFFFFFF) :
           (disp == 4'b0100) ? {8'h4F, 8'h4F, (xs < 8'h7F) ? 8'h7F - xs : 8'h00} :
           (disp == 4'b0010) ? 24'hFFFFFF :
           (disp == 4'b0001) ? 24'h008000 : 24'h000000;
      pix = bg;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) if (layers_on && bus.layer_hit[i]) pix = pal[i];
   end
   // Stage 1 registers the resolved color with the level it is drawn at; stage 2 scales it
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         c1 <= '0;
         l1 <= '0;
         bus.VGA_R <= '0;
         bus.VGA_G <= '0;
         bus.VGA_B <= '0;
      end else begin
         c1 <= pix;
         l1 <= level;
         bus.VGA_R <= scale(c1[23:16], l1);
         bus.VGA_G <= scale(c1[15:8], l1);
         bus.VGA_B <= scale(c1[7:0], l1);
      end
   end
endmodule

// File: tb/tb_layer_color_mapper.sv
// tb_layer_color_mapper: directed vectors for fade sequencing, layer priority, palette timing and reset
module tb_layer_color_mapper;
   logic Clk = 1'b0;
   logic Reset;
   int errs = 0;
   int checks = 0;
   logic [7:0] lv;
   layer_color_mapper_if #(.NUM_LAYERS(4)) bus ();
   layer_color_mapper #(.NUM_LAYERS(4), .FADE_LOG2(4)) dut (.Clk(Clk), .Reset(Reset), .bus(bus.slave));
   always #5 Clk = ~Clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [23:0] rgb();
      return {bus.VGA_R, bus.VGA_G, bus.VGA_B};
   endfunction
   task automatic cyc(input int n);
      repeat (n) @(negedge Clk);
   endtask
   task automatic tick();
      bus.frame_tick = 1'b1;
      @(negedge Clk);
      bus.frame_tick = 1'b0;
      cyc(2);
   endtask
   task automatic ticks(input int n);
      repeat (n) tick();
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
   initial begin
      Reset = 1'b1;
      bus.frame_tick = 0; bus.status = 4'b1000; bus.layer_hit = '0; bus.cover_black = 0;
      bus.DrawX = '0; bus.DrawY = '0; bus.pal_we = 0; bus.pal_addr = '0; bus.pal_data = '0;
      cyc(2);
      chk("rst_rgb", rgb(), 24'h0);
      chk("rst_disp", bus.disp_status, 4'b1000);
      chk("rst_busy", bus.fade_busy, 1);
      Reset = 1'b0;
      cyc(2);
      chk("lvl0", rgb(), 24'h0);
      for (int k = 1; k <= 16; k++) begin
         tick();
         lv = 8'(k * 16 - 1);
         chk("fadein", rgb(), {lv, lv, lv});
         if (k == 15) chk("busy15", bus.fade_busy, 1);
      end
      chk("busy16", bus.fade_busy, 0);
      bus.status = 4'b0100; bus.DrawX = 10'd639;
      cyc(2);
      chk("busy_out", bus.fade_busy, 1);
      ticks(8);
      chk("out8", rgb(), 24'h7F7F7F);
      ticks(8);
      chk("out16", rgb(), 24'h0);
      chk("disp_hold", bus.disp_status, 4'b1000);
      tick();
      chk("disp_play", bus.disp_status, 4'b0100);
      ticks(16);
      chk("play_idle", bus.fade_busy, 0);
      chk("play_bg639", rgb(), 24'h4F4F30);
      bus.DrawX = 10'd0; cyc(2);
      chk("play_bg0", rgb(), 24'h4F4F7F);
      bus.DrawX = 10'd1023; cyc(2);
      chk("play_sat", rgb(), 24'h4F4F00);
      bus.DrawX = 10'd639; cyc(2);
      bus.layer_hit = 4'b0110; cyc(1);
      chk("lat1", rgb(), 24'h4F4F30);
      cyc(1);
      chk("lat2", rgb(), 24'hFFFF00);
      bus.layer_hit = 4'b1000; cyc(2);
      chk("layer3", rgb(), 24'h101010);
      bus.layer_hit = 4'b1100; cyc(2);
      chk("layer2", rgb(), 24'h404040);
      bus.layer_hit = 4'b1111; cyc(2);
      chk("layer0", rgb(), 24'h000000);
      bus.layer_hit = 4'b0010; cyc(2);
      bus.pal_we = 1; bus.pal_addr = 2'd1; bus.pal_data = 24'h123456;
      cyc(1);
      bus.pal_we = 0;
      cyc(1);
      chk("pw_n2", rgb(), 24'hFFFF00);
      cyc(1);
      chk("pw_n3", rgb(), 24'h123456);
      bus.layer_hit = 4'b0000;
      bus.status = 4'b0001; cyc(2);
      ticks(17);
      chk("disp_lose", bus.disp_status, 4'b0001);
      ticks(5);
      chk("lose5", rgb(), 24'h002800);
      bus.status = 4'b0010; cyc(2);
      chk("nojump", rgb(), 24'h002800);
      chk("busy_rev", bus.fade_busy, 1);
      ticks(5);
      chk("rev0", rgb(), 24'h0);
      chk("rev_disp", bus.disp_status, 4'b0001);
      tick();
      chk("disp_win", bus.disp_status, 4'b0010);
      ticks(16);
      chk("win_idle", bus.fade_busy, 0);
      chk("win_bg", rgb(), 24'hFFFFFF);
      bus.layer_hit = 4'b0010; cyc(2);
      chk("win_layer", rgb(), 24'h123456);
      bus.layer_hit = 4'b0000;
      bus.status = 4'b0001; cyc(2);
      ticks(3);
      chk("out13", rgb(), 24'hCFCFCF);
      #2 Reset = 1'b1;
      #1;
      chk("arst_rgb", rgb(), 24'h0);
      chk("arst_disp", bus.disp_status, 4'b1000);
      chk("arst_busy", bus.fade_busy, 1);
      bus.status = 4'b1000; bus.cover_black = 1; bus.layer_hit = 4'b0010;
      @(negedge Clk);
      Reset = 1'b0;
      cyc(2);
      tick();
      chk("cover", rgb(), 24'h000000);
      bus.cover_black = 0; cyc(2);
      chk("restart1", rgb(), 24'h0F0F0F);
      ticks(15);
      bus.layer_hit = 4'b0000;
      bus.status = 4'b0011; cyc(2);
      ticks(33);
      chk("bad_disp", bus.disp_status, 4'b0011);
      chk("bad_rgb", rgb(), 24'h0);
      chk("bad_idle", bus.fade_busy, 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
